// File: rtl/mlp_pkg.sv
// Shared constants for the mlp dot-product sequencer: FSM encoding, lane geometry
// and int8 saturation bounds.
package mlp_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int ACC_W  = 32;
    localparam int PROD_W = 2 * LANE_W;

    localparam int signed Q_MIN = -128;
    localparam int signed Q_MAX = 127;

    localparam logic [LANE_W-1:0] Q_MIN_BYTE = 8'h80;
    localparam logic [LANE_W-1:0] Q_MAX_BYTE = 8'h7F;

endpackage

// File: rtl/mlp_mac4.sv
// Combinational 4-lane signed int8 multiply-accumulate: sum = sum_in + sum of lane products.
module mlp_mac4
    import mlp_pkg::*;
(
    input  logic [ACC_W-1:0]          sum_in,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    output logic [ACC_W-1:0]          sum
);

    logic signed [PROD_W-1:0] prod [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod[i] = $signed(a[LANE_W*i +: LANE_W]) * $signed(b[LANE_W*i +: LANE_W]);
    end

    // Products are sign-extended to the accumulator width; the sum wraps modulo 2^32.
    always_comb begin
        sum = sum_in;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + ACC_W'(prod[i]);
        end
    end

endmodule

// File: rtl/mlp_dot_seq.sv
// Dot-product sequencer: bias load, streamed 4-lane MAC, int8 requantization.
// Define MLP_SEQ_RELU_EN to clamp negative requantized results to zero.
module mlp_dot_seq
    import mlp_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic [31:0]        bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_acc,
    output logic [7:0]         res_q,
    output logic               busy
);

    logic [STATE_W-1:0]  state;
    logic [ACC_W-1:0]    acc;
    logic [LEN_W-1:0]    cnt;
    logic [ACC_W-1:0]    mac_sum;
    logic signed [ACC_W-1:0] shifted;
    logic [LANE_W-1:0]   q;

    mlp_mac4 u_mac (
        .sum_in (acc),
        .a      (a),
        .b      (b),
        .sum    (mac_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc   <= bias;
                        cnt   <= len;
                        state <= (len == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc <= mac_sum;
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // acc is frozen here, so res_acc/res_q stay stable until the handshake.
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shifted = $signed(acc) >>> SHIFT;
        if (shifted > Q_MAX) begin
            q = Q_MAX_BYTE;
        end else if (shifted < Q_MIN) begin
            q = Q_MIN_BYTE;
        end else begin
            q = shifted[LANE_W-1:0];
        end
`ifdef MLP_SEQ_RELU_EN
        if (shifted < 0) begin
            q = '0;
        end
`endif
    end

    assign in_ready  = (state == ST_ACCUM);
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign res_acc   = acc;
    assign res_q     = q;

endmodule
